// File: rtl/sli_trig_gen.sv
// Structured-light camera trigger sequencer: arms on a pattern-change flag, then
// waits for vsync and runs delay, exposure and guard phases, with a one-deep request queue.
module sli_trig_gen #(
    parameter int CNT_W     = 20,
    parameter int DELAY_CYC = 0,
    parameter int WIDTH_CYC = 524288,
    parameter int GAP_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flag,
    input  logic        in_vsync,
    output logic        trig,
    output logic        busy,
    output logic        pending,
    output logic [15:0] trig_count,
    output logic [7:0]  missed_count
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        EXPOSE,
        GAP
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(DELAY_CYC);
    localparam logic [CNT_W-1:0] WIDTH_LD = CNT_W'(WIDTH_CYC);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             vs_q;
    logic             vs_rise;
    logic             acc;
    logic             pending_nx;
    logic             miss_inc;
    logic             start;
    logic             in_seq;

    assign vs_rise = in_vsync & ~vs_q;
    assign acc     = flag & en;
    assign busy    = (state != IDLE);
    assign in_seq  = (state == DELAY) || (state == EXPOSE) || (state == GAP);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pending_nx = pending;
        miss_inc   = 1'b0;
        start      = 1'b0;

        case (state)
            IDLE: begin
                if (acc) begin
                    state_nx = ARMED;
                end
            end
            ARMED: begin
                if (vs_rise) begin
                    if (DELAY_CYC == 0) begin
                        state_nx = EXPOSE;
                        cnt_nx   = WIDTH_LD;
                        start    = 1'b1;
                    end else begin
                        state_nx = DELAY;
                        cnt_nx   = DELAY_LD;
                    end
                end
            end
            DELAY: begin
                if (cnt == CNT_ONE) begin
                    state_nx = EXPOSE;
                    cnt_nx   = WIDTH_LD;
                    start    = 1'b1;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            EXPOSE: begin
                if (cnt == CNT_ONE) begin
                    state_nx = GAP;
                    cnt_nx   = GAP_LD;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            GAP: begin
                cnt_nx = cnt - CNT_ONE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (in_seq && acc) begin
            if (pending) begin
                miss_inc = 1'b1;
            end else begin
                pending_nx = 1'b1;
            end
        end

        // A request queued on the last guard cycle (even that same cycle) re-arms immediately.
        if ((state == GAP) && (cnt == CNT_ONE)) begin
            state_nx   = pending_nx ? ARMED : IDLE;
            pending_nx = 1'b0;
            cnt_nx     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            vs_q         <= 1'b0;
            pending      <= 1'b0;
            trig         <= 1'b0;
            trig_count   <= 16'd0;
            missed_count <= 8'd0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            vs_q    <= in_vsync;
            pending <= pending_nx;
            trig    <= (state_nx == EXPOSE);
            if (start) begin
                trig_count <= trig_count + 16'd1;
            end
            if (miss_inc && (missed_count != 8'hFF)) begin
                missed_count <= missed_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/sli_trig_gen.md
Name: sli_trig_gen

Overview:
- Downstream of the pixel pipeline.
- Consumes the one-cycle pattern-change flag and the pass-through vsync, and produces the camera exposure trigger for the structured-light capture.
- Replaces the fixed-width trigger counter with a programmable delay/width/guard sequencer.
- Adds a one-deep request queue plus trigger and missed-request counters, which feed the debug 7-segment path.

Parameters:
- CNT_W, 20, width of the delay/width/gap counters.
- DELAY_CYC, 0, cycles from the qualifying vsync rising edge to trig assertion (0 = next cycle).
- WIDTH_CYC, 524288, trig high time in cycles (0x80000, ~7.06 ms at pixel clock); must be ≥1.
- GAP_CYC, 16, minimum trig-low guard cycles after each exposure; must be ≥1.

Ports:
- clk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  1 = accept flags; 0 = flags ignored (an exposure in progress still completes).
- flag  in  1  one-cycle pulse: pattern/frame changed; request a capture.
- in_vsync  in  1  vsync, active-high, synchronous to clk.
- trig  out  1  camera trigger, registered.
- busy  out  1  high in any state other than IDLE.
- pending  out  1  one queued request waiting behind the current exposure.
- trig_count  out  16  exposures started; wraps at 0xFFFF→0.
- missed_count  out  8  requests dropped; saturates at 0xFF.

Behaviour:
- Reset (async, while rst=1): state=IDLE, trig=0, pending=0, busy=0, trig_count=0, missed_count=0, counters=0, vs_q=0.
- Edge detect: vs_q registers in_vsync; vs_rise = in_vsync & ~vs_q.
- acc = flag & en.
- States:
  - IDLE: acc → ARMED next cycle. A vs_rise in the same cycle as acc is not used; the next vs_rise is needed.
  - ARMED: waits for vs_rise. acc while ARMED is merged into the current request (no count, no pending).
    - On vs_rise, DELAY_CYC=0: → EXPOSE; trig=1 on the next cycle; trig_count increments on that same cycle.
    - On vs_rise, DELAY_CYC>0: → DELAY; counter loaded with DELAY_CYC.
  - DELAY: counts down to 1, then → EXPOSE. trig first goes high exactly DELAY_CYC+1 cycles after the vs_rise cycle.
  - EXPOSE: trig=1 for exactly WIDTH_CYC consecutive cycles, then → GAP with trig=0.
  - GAP: trig=0 for exactly GAP_CYC cycles, then:
    - pending=1 → ARMED, and pending clears on the same cycle;
    - pending=0 → IDLE.
- acc during DELAY/EXPOSE/GAP:
  - pending=0 → pending=1.
  - pending=1 → missed_count+1 (saturating).
  - acc on the final GAP cycle counts as if in GAP: it sets pending, or is missed if pending was already set.
- en deasserted mid-sequence: the current sequence runs to completion. pending is kept if already set.
- vs_rise outside ARMED is ignored.
- trig is never asserted outside EXPOSE. trig pulses are always separated by ≥GAP_CYC low cycles.
- Counters are CNT_W wide, unsigned. Parameter values ≥2^CNT_W are illegal; the bench checks this with an assertion at elaboration.
- rst asserted mid-EXPOSE: trig drops asynchronously. After release the block restarts in IDLE.

Test Plan:
(Bench parameters: DELAY_CYC=3, WIDTH_CYC=8, GAP_CYC=4, CNT_W=8.)
- Basic capture: flag at cycle 10, vsync rising at cycle 20 → trig high cycles 24–31, low from cycle 32; trig_count=1; busy falls at cycle 36.
- Same-cycle flag and vs_rise from IDLE, with the next vs_rise at cycle 50 → no trig until cycle 54; exactly 8 high cycles.
- Back-to-back requests: flag at cycle 10, vs_rise at cycle 20, flag at cycles 26 and 28 → pending=1 at cycle 27; missed_count=1 at cycle 29; after GAP the block re-arms; the next vs_rise at cycle 60 gives trig on cycles 64–71; trig_count=2.
- en=0 with flag pulses → no trig, trig_count=0, missed_count=0. en dropped during EXPOSE → the pulse still lasts 8 cycles.
- Async reset: rst asserted at cycle 27 (mid-EXPOSE) → trig=0 within the same cycle; all counts 0; a new flag/vsync after release yields a normal 8-cycle trig.
- Counter wrap and saturation: 65536 captures → trig_count returns to 0. 300 dropped requests → missed_count holds at 255.
